// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock: state encodings, combination geometry,
// and small helpers used by the supervisor.
package lock_pkg;

  localparam int NIBBLE_W = 4;
  localparam int DIGITS   = 4;
  localparam int COMBO_W  = NIBBLE_W * DIGITS;

  localparam logic [1:0] LAST_DIGIT = 2'(DIGITS - 1);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'b000,
    ST_PROG    = 3'b101,
    ST_LOCKOUT = 3'b110,
    ST_OPEN    = 3'b111
  } lock_state_t;

  // Digit index 0 is the most significant nibble of the combination.
  function automatic logic [NIBBLE_W-1:0] combo_nibble(input logic [COMBO_W-1:0] combo,
                                                       input logic [1:0] idx);
    return combo[COMBO_W - 1 - NIBBLE_W * int'(idx) -: NIBBLE_W];
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
// Result is visible one clock after load/dec; no backpressure.
module lock_timer #(
  parameter int W = 28
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_supervisor.sv
// Combination lock supervisor: 4-digit entry, lockout after repeated failures, auto-relock,
// and reprogramming from OPEN. All outputs registered, one clock after the causing strobe.
module lock_supervisor
  import lock_pkg::*;
#(
  parameter logic [COMBO_W-1:0] COMBO_INIT     = 16'h8421,
  parameter int                 MAX_FAILS      = 3,
  parameter int                 LOCKOUT_CYCLES = 100000000,
  parameter int                 RELOCK_CYCLES  = 250000000,
  parameter int                 ENTRY_TIMEOUT  = 150000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       digit_stb,
  input  logic [3:0] digit,
  input  logic       prog_stb,
  input  logic       close_stb,
  output logic       open,
  output logic [2:0] state_o,
  output logic [1:0] digit_cnt,
  output logic [1:0] fails,
  output logic       lockout,
  output logic       err
);

  localparam int TMR_W = $clog2(max3(LOCKOUT_CYCLES, RELOCK_CYCLES, ENTRY_TIMEOUT) + 1);

  lock_state_t        state, state_n;
  logic [1:0]         cnt_n, fails_n;
  logic               mismatch, mis_n, mis_hit;
  logic [COMBO_W-1:0] combo, combo_n, shadow, shadow_n;
  logic               err_n;

  logic               t_load, t_dec, t_zero, t_last;
  logic [TMR_W-1:0]   t_val, t_count;

  lock_timer #(.W(TMR_W)) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .count    (t_count),
    .zero     (t_zero)
  );

  // Transitions fire on the edge where the count drops from 1 to 0, so a load of N
  // keeps the block in the timed condition for exactly N clocks.
  assign t_last = t_zero || (t_count == TMR_W'(1));

  always_comb begin
    state_n  = state;
    cnt_n    = digit_cnt;
    fails_n  = fails;
    mis_n    = mismatch;
    combo_n  = combo;
    shadow_n = shadow;
    err_n    = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;
    t_dec    = 1'b0;
    mis_hit  = mismatch | (digit != combo_nibble(combo, digit_cnt));

    case (state)
      ST_ENTRY: begin
        if (digit_stb) begin
          if (digit_cnt == LAST_DIGIT) begin
            cnt_n = 2'd0;
            mis_n = 1'b0;
            if (!mis_hit) begin
              state_n = ST_OPEN;
              fails_n = 2'd0;
              t_load  = 1'b1;
              t_val   = TMR_W'(RELOCK_CYCLES);
            end else begin
              err_n   = 1'b1;
              fails_n = fails + 2'd1;
              if (int'(fails) + 1 >= MAX_FAILS) begin
                state_n = ST_LOCKOUT;
                t_load  = 1'b1;
                t_val   = TMR_W'(LOCKOUT_CYCLES);
              end
            end
          end else begin
            cnt_n  = digit_cnt + 2'd1;
            mis_n  = mis_hit;
            t_load = 1'b1;
            t_val  = TMR_W'(ENTRY_TIMEOUT);
          end
        end else if (digit_cnt != 2'd0) begin
          // Abandoned partial entry: discard silently, no fail recorded.
          t_dec = 1'b1;
          if (t_last) begin
            cnt_n = 2'd0;
            mis_n = 1'b0;
          end
        end
      end

      ST_LOCKOUT: begin
        t_dec = 1'b1;
        if (digit_stb) begin
          err_n = 1'b1;
        end
        if (t_last) begin
          state_n = ST_ENTRY;
          fails_n = 2'd0;
        end
      end

      ST_OPEN: begin
        t_dec = 1'b1;
        if (close_stb) begin
          state_n = ST_ENTRY;
        end else if (prog_stb) begin
          state_n  = ST_PROG;
          cnt_n    = 2'd0;
          shadow_n = '0;
        end else if (t_last) begin
          state_n = ST_ENTRY;
        end
      end

      ST_PROG: begin
        if (close_stb) begin
          state_n = ST_ENTRY;
          cnt_n   = 2'd0;
        end else if (digit_stb) begin
          shadow_n = {shadow[COMBO_W-NIBBLE_W-1:0], digit};
          if (digit_cnt == LAST_DIGIT) begin
            combo_n = {shadow[COMBO_W-NIBBLE_W-1:0], digit};
            state_n = ST_ENTRY;
            cnt_n   = 2'd0;
          end else begin
            cnt_n = digit_cnt + 2'd1;
          end
        end
      end

      default: begin
        state_n = ST_ENTRY;
        cnt_n   = 2'd0;
        mis_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= ST_ENTRY;
      digit_cnt <= 2'd0;
      fails     <= 2'd0;
      mismatch  <= 1'b0;
      combo     <= COMBO_INIT;
      shadow    <= '0;
      open      <= 1'b0;
      lockout   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      digit_cnt <= cnt_n;
      fails     <= fails_n;
      mismatch  <= mis_n;
      combo     <= combo_n;
      shadow    <= shadow_n;
      open      <= (state_n == ST_OPEN);
      lockout   <= (state_n == ST_LOCKOUT);
      err       <= err_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor with shortened timers; every cycle's expected
// outputs are queued when stimulus is driven and compared after the clock edge.
module tb_lock_supervisor;

  localparam logic [2:0] E = 3'b000;
  localparam logic [2:0] P = 3'b101;
  localparam logic [2:0] L = 3'b110;
  localparam logic [2:0] O = 3'b111;

  typedef struct {
    logic       rst;
    logic       stb;
    logic [3:0] dig;
    logic       prog;
    logic       close;
    logic [2:0] st;
    logic [1:0] cnt;
    logic [1:0] fl;
    logic       op;
    logic       lk;
    logic       er;
  } vec_t;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       digit_stb = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       prog_stb = 1'b0;
  logic       close_stb = 1'b0;
  logic       open, lockout, err;
  logic [2:0] state_o;
  logic [1:0] digit_cnt, fails;

  int compared = 0;
  int mismatched = 0;
  int step = 0;
  vec_t sb[$];
  vec_t tbl[24];

  lock_supervisor #(
    .COMBO_INIT     (16'h8421),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (20),
    .RELOCK_CYCLES  (30),
    .ENTRY_TIMEOUT  (10)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .digit_stb (digit_stb),
    .digit     (digit),
    .prog_stb  (prog_stb),
    .close_stb (close_stb),
    .open      (open),
    .state_o   (state_o),
    .digit_cnt (digit_cnt),
    .fails     (fails),
    .lockout   (lockout),
    .err       (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic vec_t mk(input logic rst, input logic stb, input logic [3:0] dig,
                              input logic prog, input logic close, input logic [2:0] st,
                              input logic [1:0] cnt, input logic [1:0] fl, input logic er);
    vec_t v;
    v.rst = rst; v.stb = stb; v.dig = dig; v.prog = prog; v.close = close;
    v.st = st; v.cnt = cnt; v.fl = fl; v.er = er;
    v.op = (st == O);
    v.lk = (st == L);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t x;
    reset = v.rst; digit_stb = v.stb; digit = v.dig; prog_stb = v.prog; close_stb = v.close;
    sb.push_back(v);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0; digit_stb = 1'b0; prog_stb = 1'b0; close_stb = 1'b0;
    step++;
    if (sb.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      x = sb.pop_front();
      chk("state",     int'(state_o),   int'(x.st));
      chk("digit_cnt", int'(digit_cnt), int'(x.cnt));
      chk("fails",     int'(fails),     int'(x.fl));
      chk("open",      int'(open),      int'(x.op));
      chk("lockout",   int'(lockout),   int'(x.lk));
      chk("err",       int'(err),       int'(x.er));
    end
  endtask

  task automatic idle(input int n, input logic [2:0] st, input logic [1:0] cnt,
                      input logic [1:0] fl);
    for (int i = 0; i < n; i++) apply(mk(0, 0, 4'd0, 0, 0, st, cnt, fl, 0));
  endtask

  // Four digits MS first; the first three expect st_mid with cnt 1..3.
  task automatic code4(input logic [15:0] c, input logic [2:0] st_mid, input logic [1:0] fl_mid,
                       input logic [2:0] st_end, input logic [1:0] fl_end, input logic er_end);
    apply(mk(0, 1, c[15:12], 0, 0, st_mid, 2'd1, fl_mid, 0));
    apply(mk(0, 1, c[11:8],  0, 0, st_mid, 2'd2, fl_mid, 0));
    apply(mk(0, 1, c[7:4],   0, 0, st_mid, 2'd3, fl_mid, 0));
    apply(mk(0, 1, c[3:0],   0, 0, st_end, 2'd0, fl_end, er_end));
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 4'd0, 0, 0, E, 0, 0, 0);
    tbl[1]  = mk(0, 1, 4'd8, 0, 0, E, 1, 0, 0);
    tbl[2]  = mk(0, 1, 4'd4, 0, 0, E, 2, 0, 0);
    tbl[3]  = mk(0, 1, 4'd2, 0, 0, E, 3, 0, 0);
    tbl[4]  = mk(0, 1, 4'd1, 0, 0, O, 0, 0, 0);
    tbl[5]  = mk(0, 0, 4'd0, 0, 1, E, 0, 0, 0);
    tbl[6]  = mk(0, 0, 4'd0, 1, 0, E, 0, 0, 0);
    tbl[7]  = mk(0, 0, 4'd0, 0, 1, E, 0, 0, 0);
    tbl[8]  = mk(0, 1, 4'd1, 0, 0, E, 1, 0, 0);
    tbl[9]  = mk(0, 1, 4'd4, 0, 0, E, 2, 0, 0);
    tbl[10] = mk(0, 1, 4'd2, 0, 0, E, 3, 0, 0);
    tbl[11] = mk(0, 1, 4'd1, 0, 0, E, 0, 1, 1);
    tbl[12] = mk(0, 0, 4'd0, 0, 0, E, 0, 1, 0);
    tbl[13] = mk(0, 1, 4'd9, 0, 0, E, 1, 1, 0);
    tbl[14] = mk(0, 1, 4'd9, 0, 0, E, 2, 1, 0);
    tbl[15] = mk(0, 1, 4'd9, 0, 0, E, 3, 1, 0);
    tbl[16] = mk(0, 1, 4'd9, 0, 0, E, 0, 2, 1);
    tbl[17] = mk(0, 1, 4'd0, 0, 0, E, 1, 2, 0);
    tbl[18] = mk(0, 1, 4'd0, 0, 0, E, 2, 2, 0);
    tbl[19] = mk(0, 1, 4'd0, 0, 0, E, 3, 2, 0);
    tbl[20] = mk(0, 1, 4'd0, 0, 0, L, 0, 3, 1);
    tbl[21] = mk(0, 1, 4'd5, 0, 0, L, 0, 3, 1);
    tbl[22] = mk(0, 0, 4'd0, 1, 1, L, 0, 3, 0);
    tbl[23] = mk(0, 0, 4'd0, 0, 0, L, 0, 3, 0);

    for (int i = 0; i < 24; i++) apply(tbl[i]);

    // Lockout entered at tbl[20]; 20 clocks in total before returning to ENTRY.
    idle(16, L, 0, 3);
    idle(1, E, 0, 0);

    // Reprogram to 3333, old code now fails, new code opens.
    code4(16'h8421, E, 0, O, 0, 0);
    apply(mk(0, 0, 4'd0, 1, 0, P, 0, 0, 0));
    code4(16'h3333, P, 0, E, 0, 0);
    code4(16'h8421, E, 0, E, 1, 1);
    code4(16'h3333, E, 1, O, 0, 0);
    apply(mk(0, 0, 4'd0, 1, 1, E, 0, 0, 0));

    // Abort PROG with close coinciding with a digit; combination must be unchanged.
    code4(16'h3333, E, 0, O, 0, 0);
    apply(mk(0, 0, 4'd0, 1, 0, P, 0, 0, 0));
    apply(mk(0, 1, 4'd7, 0, 0, P, 1, 0, 0));
    apply(mk(0, 1, 4'd9, 0, 1, E, 0, 0, 0));
    code4(16'h3333, E, 0, O, 0, 0);

    // Auto-relock after 30 idle clocks in OPEN.
    idle(29, O, 0, 0);
    idle(1, E, 0, 0);

    // Partial wrong entry times out after 10 clocks without touching fails.
    code4(16'h1111, E, 0, E, 1, 1);
    apply(mk(0, 1, 4'd1, 0, 0, E, 1, 1, 0));
    apply(mk(0, 1, 4'd2, 0, 0, E, 2, 1, 0));
    idle(9, E, 2, 1);
    idle(1, E, 0, 1);
    code4(16'h3333, E, 1, O, 0, 0);

    // Reset in PROG after two digits restores the initial combination.
    apply(mk(0, 0, 4'd0, 1, 0, P, 0, 0, 0));
    apply(mk(0, 1, 4'd5, 0, 0, P, 1, 0, 0));
    apply(mk(0, 1, 4'd5, 0, 0, P, 2, 0, 0));
    apply(mk(1, 0, 4'd0, 0, 0, E, 0, 0, 0));
    code4(16'h3333, E, 0, E, 1, 1);
    code4(16'h8421, E, 1, O, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lock_supervisor.md
LOCK_SUPERVISOR -- requirements
Module: lock_supervisor

Interface
REQ-001 Parameters SHALL be, one per line:
  COMBO_INIT, 16'h8421, reset combination; first digit in [15:12].
  MAX_FAILS, 3, consecutive failed attempts that trigger lockout.
  LOCKOUT_CYCLES, 100000000, lockout duration in clocks (2 s).
  RELOCK_CYCLES, 250000000, auto-relock time in OPEN (5 s).
  ENTRY_TIMEOUT, 150000000, max inter-digit gap before partial entry is discarded.
REQ-002 Ports SHALL be, one per line:
  CLOCK_50  in  1  system clock, 50 MHz.
  reset  in  1  reset, synchronous, active-high.
  digit_stb  in  1  one-cycle pulse, digit entered (already debounced and edge-detected).
  digit  in  4  digit value, sampled when digit_stb=1.
  prog_stb  in  1  one-cycle pulse, request to reprogram the combination.
  close_stb  in  1  one-cycle pulse, request to relock or abort.
  open  out  1  lock released.
  state_o  out  3  current state encoding.
  digit_cnt  out  2  digits accepted in the current sequence.
  fails  out  2  consecutive failed attempts.
  lockout  out  1  lockout active.
  err  out  1  one-cycle pulse: strobe rejected or attempt failed.

Function
REQ-003 States SHALL be ENTRY=3'b000, PROG=3'b101, LOCKOUT=3'b110, OPEN=3'b111; any other value SHALL go to ENTRY on the next clock.
REQ-004 In ENTRY, each digit_stb SHALL increment digit_cnt (wrapping 3->0) and SHALL set a sticky mismatch flag if digit differs from the combo nibble selected by digit_cnt.
REQ-005 Accept/reject SHALL be decided only on the 4th digit; no early reject, so attempt length and timing never depend on which digit was wrong.
REQ-006 On the 4th digit with mismatch clear, the next state SHALL be OPEN, fails SHALL clear, and the relock timer SHALL load RELOCK_CYCLES.
REQ-007 On the 4th digit with mismatch set, the block SHALL pulse err and increment fails.
  - If fails reaches MAX_FAILS: go to LOCKOUT, load LOCKOUT_CYCLES.
  - Otherwise: stay in ENTRY.
  - In both cases, clear mismatch and digit_cnt.
REQ-008 In ENTRY with digit_cnt>0, ENTRY_TIMEOUT clocks without digit_stb SHALL clear digit_cnt and mismatch; this SHALL NOT count as a fail.
REQ-009 In LOCKOUT, the timer SHALL decrement each clock and digit_stb SHALL pulse err and otherwise be ignored.
REQ-010 When the LOCKOUT timer reaches 0, the block SHALL go to ENTRY and clear fails.
REQ-011 In OPEN, close_stb or relock-timer expiry SHALL go to ENTRY; prog_stb SHALL go to PROG; digit_stb SHALL be ignored.
REQ-012 If close_stb and prog_stb arrive in the same cycle in OPEN, close SHALL win.
REQ-013 In PROG, four digit_stb SHALL fill a shadow register MS nibble first; on the 4th, the combo register SHALL update atomically and the block SHALL go to ENTRY (locked).
REQ-014 close_stb in PROG SHALL abort to ENTRY with combo unchanged; if close_stb and digit_stb coincide, close SHALL win.
REQ-015 prog_stb outside OPEN and close_stb outside OPEN/PROG SHALL be ignored with no err.
REQ-016 open SHALL equal (state==OPEN) and lockout SHALL equal (state==LOCKOUT), both registered.
REQ-017 Timer width SHALL be clog2 of the largest cycle parameter; the timer SHALL saturate at 0 and never wrap.

Reset
REQ-018 On reset, the block SHALL take these values:
  - state=ENTRY, open=0, lockout=0, err=0.
  - digit_cnt=0, fails=0, mismatch=0, timer=0.
  - combo=COMBO_INIT; shadow register cleared.
REQ-019 Reset asserted mid-sequence, in PROG, or in LOCKOUT SHALL abandon the operation within one clock; a pending PROG update SHALL NOT commit.

Structure
REQ-020 State encodings, combo nibble width, and digits-per-combination (4) SHALL live in shared package lock_pkg.
REQ-021 One sub-module lock_timer SHALL be used: a loadable down-counter with a zero flag, shared by the lockout, relock, and entry-timeout functions (only one is active per state).

Verification
REQ-022 The bench SHALL override cycle parameters to LOCKOUT_CYCLES=20, RELOCK_CYCLES=30, ENTRY_TIMEOUT=10 and SHALL cover:
  - Digits 8,4,2,1 -> open=1 one clock after the 4th strobe; fails=0.
  - Digits 1,4,2,1 -> no state change until the 4th digit; then err pulse, fails=1, state ENTRY.
  - Three wrong attempts -> lockout=1; digit_stb during lockout -> err, state stays LOCKOUT; after 20 clocks -> ENTRY, fails=0.
  - OPEN, prog_stb, digits 3,3,3,3 -> ENTRY; then 8,4,2,1 fails and 3,3,3,3 opens; close_stb+prog_stb together in OPEN -> ENTRY, not PROG.
  - OPEN, idle 30 clocks -> ENTRY; two digits then idle 10 clocks -> digit_cnt=0, fails unchanged.
  - Reset in PROG after 2 digits -> ENTRY, combo=16'h8421.
